// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared state encoding, port indices and SRAM strobe bundle
package sram_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, HOLD = 2'd3} state_t;
  localparam logic PORT_DBG = 1'b0;
  localparam logic PORT_CPU = 1'b1;
  localparam int WAIT_DEFAULT = 3;
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
  } strobe_t;
  localparam strobe_t STB_IDLE = '1;
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: one requester's handshake and bus towards the SRAM arbiter
interface sram_arbiter_if #(parameter int AW = 18) ();
  logic          req;
  logic [AW-1:0] addr;
  logic          r;
  logic [1:0]    w;
  logic [15:0]   wdata;
  logic          ack;
  modport master (output req, addr, r, w, wdata, input ack);
  modport slave (input req, addr, r, w, wdata, output ack);
endinterface

// File: rtl/sram_arbiter_rr.sv
// sram_arbiter_rr: two-requester round-robin arbiter with a registered last-grant pointer
module sram_arbiter_rr (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last_q, last_d;
  // a tie goes to the port not served last; pointer follows the grant when taken
  always_comb begin
    grant[0] = req[0] & (~req[1] | last_q);
    grant[1] = req[1] & (~req[0] | ~last_q);
    last_d = advance ? grant[1] : last_q;
  end
  // pointer resets to "port 1 served last" so port 0 wins the first tie
  always_ff @(posedge clk) last_q <= reset ? 1'b1 : last_d;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: registered access sequencer sharing one async SRAM between debug and CPU ports
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW   = 18,
  parameter int WAIT = WAIT_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.slave  m0,
  sram_arbiter_if.slave  m1,
  output logic [15:0]    rdata,
  output logic           grant,
  output logic           busy,
  output logic [AW-1:0]  sram_addr,
  input  logic [15:0]    sram_dq_i,
  output logic [15:0]    sram_dq_o,
  output logic           sram_dq_oe,
  output logic           sram_ce_n,
  output logic           sram_oe_n,
  output logic           sram_we_n,
  output logic           sram_ub_n,
  output logic           sram_lb_n
);
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          sel_q, sel_d, rd_q, rd_d;
  logic [1:0]    w_q, w_d, gnt, ack_q, ack_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   dq_o_q, dq_o_d, rdata_q, rdata_d;
  logic          dq_oe_q, dq_oe_d, busy_q, busy_d, act, wr_acc;
  strobe_t       stb_q, stb_d;

  sram_arbiter_rr u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({m1.req, m0.req}),
    .advance (state_q == IDLE && (m0.req || m1.req)),
    .grant   (gnt)
  );

  // next state, request latch, and strobe values registered so every pin is glitch-free
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    w_d     = w_q;
    addr_d  = addr_q;
    dq_o_d  = dq_o_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (gnt != 2'b00) begin
        sel_d   = gnt[1];
        w_d     = sel_d ? m1.w : m0.w;
        rd_d    = (sel_d ? m1.r : m0.r) && w_d == 2'b00;
        state_d = (rd_d || w_d != 2'b00) ? SETUP : HOLD;
        addr_d  = state_d == SETUP ? (sel_d ? m1.addr : m0.addr) : addr_q;
        dq_o_d  = state_d == SETUP ? (sel_d ? m1.wdata : m0.wdata) : dq_o_q;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 4'(WAIT - 1);
      end
      ACCESS: begin
        state_d = cnt_q == 4'd0 ? HOLD : ACCESS;
        cnt_d   = cnt_q - 4'd1;
        rdata_d = (cnt_q == 4'd0 && rd_q) ? sram_dq_i : rdata_q;
      end
      default: state_d = IDLE;
    endcase
    act        = state_d == SETUP || state_d == ACCESS;
    wr_acc     = state_d == ACCESS && !rd_d;
    stb_d      = STB_IDLE;
    stb_d.ce_n = !act;
    stb_d.oe_n = !(act && rd_d);
    stb_d.we_n = !wr_acc;
    stb_d.ub_n = !((act && rd_d) || (wr_acc && w_d[1]));
    stb_d.lb_n = !((act && rd_d) || (wr_acc && w_d[0]));
    dq_oe_d    = (act || state_d == HOLD) && w_d != 2'b00;
    ack_d      = {state_d == HOLD && sel_d == PORT_CPU, state_d == HOLD && sel_d == PORT_DBG};
    busy_d     = state_d != IDLE;
  end

  // state and output registers; reset aborts any access with strobes released
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      rd_q    <= 1'b0;
      w_q     <= '0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      rdata_q <= '0;
      dq_oe_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      stb_q   <= STB_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      w_q     <= w_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      rdata_q <= rdata_d;
      dq_oe_q <= dq_oe_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
    end
  end

  assign m0.ack     = ack_q[0];
  assign m1.ack     = ack_q[1];
  assign rdata      = rdata_q;
  assign grant      = sel_q;
  assign busy       = busy_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = stb_q.ce_n;
  assign sram_oe_n  = stb_q.oe_n;
  assign sram_we_n  = stb_q.we_n;
  assign sram_ub_n  = stb_q.ub_n;
  assign sram_lb_n  = stb_q.lb_n;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vector bench for the SRAM arbiter with a byte-lane SRAM model
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  logic [15:0] rdata, dq_o, dq_i;
  logic [17:0] sram_addr;
  logic grant, busy, dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;
  logic [15:0] w1_rdata, w1_dq_o;
  logic [17:0] w1_addr;
  logic w1_grant, w1_busy, w1_dq_oe, w1_ce_n, w1_oe_n, w1_we_n, w1_ub_n, w1_lb_n;
  logic [15:0] mem [256] = '{default: 16'h0000};

  sram_arbiter_if i0 ();
  sram_arbiter_if i1 ();
  sram_arbiter_if j0 ();
  sram_arbiter_if j1 ();

  always #5 clk = ~clk;

  sram_arbiter #(.AW(18), .WAIT(3)) u_dut (
    .clk(clk), .reset(reset), .m0(i0), .m1(i1), .rdata(rdata), .grant(grant), .busy(busy),
    .sram_addr(sram_addr), .sram_dq_i(dq_i), .sram_dq_o(dq_o), .sram_dq_oe(dq_oe),
    .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n)
  );

  sram_arbiter #(.AW(18), .WAIT(1)) u_w1 (
    .clk(clk), .reset(reset), .m0(j0), .m1(j1), .rdata(w1_rdata), .grant(w1_grant), .busy(w1_busy),
    .sram_addr(w1_addr), .sram_dq_i(16'h0000), .sram_dq_o(w1_dq_o), .sram_dq_oe(w1_dq_oe),
    .sram_ce_n(w1_ce_n), .sram_oe_n(w1_oe_n), .sram_we_n(w1_we_n), .sram_ub_n(w1_ub_n), .sram_lb_n(w1_lb_n)
  );

  assign dq_i = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!ce_n && !we_n && dq_oe && !ub_n) mem[sram_addr[7:0]][15:8] <= dq_o[15:8];
    if (!ce_n && !we_n && dq_oe && !lb_n) mem[sram_addr[7:0]][7:0] <= dq_o[7:0];
  end

  typedef struct {
    logic        p;
    logic        r;
    logic [1:0]  w;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [7:0]  ce, oe, we, ub, lb, dqoe, bz, ack;
    logic [15:0] rdata;
    logic [15:0] mem;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input int i, input vec_t v);
    logic [7:0] ce, oe, we, ub, lb, dqoe, bz, ak, ako;
    logic [15:0] rd;
    logic g;
    logic [17:0] a;
    ce = '0; oe = '0; we = '0; ub = '0; lb = '0; dqoe = '0; bz = '0; ak = '0; ako = '0;
    rd = 'x; g = 'x; a = 'x;
    @(posedge clk); #1;
    if (v.p) begin
      i1.addr = v.addr; i1.r = v.r; i1.w = v.w; i1.wdata = v.wdata; i1.req = 1'b1;
    end else begin
      i0.addr = v.addr; i0.r = v.r; i0.w = v.w; i0.wdata = v.wdata; i0.req = 1'b1;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ce[c] = !ce_n; oe[c] = !oe_n; we[c] = !we_n; ub[c] = !ub_n; lb[c] = !lb_n;
      dqoe[c] = dq_oe; bz[c] = busy;
      ak[c] = v.p ? i1.ack : i0.ack;
      ako[c] = v.p ? i0.ack : i1.ack;
      if (c == 2) a = sram_addr;
      if (ak[c]) begin
        rd = rdata; g = grant;
        if (v.p) i1.req = 1'b0; else i0.req = 1'b0;
      end
    end
    chk($sformatf("t%0d ce_n low cycles", i), ce, v.ce);
    chk($sformatf("t%0d oe_n low cycles", i), oe, v.oe);
    chk($sformatf("t%0d we_n low cycles", i), we, v.we);
    chk($sformatf("t%0d ub_n low cycles", i), ub, v.ub);
    chk($sformatf("t%0d lb_n low cycles", i), lb, v.lb);
    chk($sformatf("t%0d dq_oe cycles", i), dqoe, v.dqoe);
    chk($sformatf("t%0d busy cycles", i), bz, v.bz);
    chk($sformatf("t%0d ack cycles", i), ak, v.ack);
    chk($sformatf("t%0d other ack", i), ako, 8'h00);
    chk($sformatf("t%0d rdata at ack", i), rd, v.rdata);
    chk($sformatf("t%0d grant at ack", i), g, v.p);
    chk($sformatf("t%0d sram word", i), mem[v.addr[7:0]], v.mem);
    if (v.r || v.w != 2'b00) chk($sformatf("t%0d sram_addr", i), a, v.addr);
  endtask

  initial begin
    int ack_port [4];
    int ack_cyc [4];
    int ack_gnt [4];
    int n, ackc;
    logic [7:0] ce, we, ak, dqoe;
    tbl[0] = '{1'b0, 1'b0, 2'b01, 18'h00123, 16'h1255, 8'h1E, 8'h00, 8'h1C, 8'h00, 8'h1C, 8'h3E, 8'h3E, 8'h20, 16'h0000, 16'h0055};
    tbl[1] = '{1'b1, 1'b0, 2'b10, 18'h00123, 16'hABCD, 8'h1E, 8'h00, 8'h1C, 8'h1C, 8'h00, 8'h3E, 8'h3E, 8'h20, 16'h0000, 16'hAB55};
    tbl[2] = '{1'b0, 1'b1, 2'b00, 18'h00123, 16'h0000, 8'h1E, 8'h1E, 8'h00, 8'h1E, 8'h1E, 8'h00, 8'h3E, 8'h20, 16'hAB55, 16'hAB55};
    tbl[3] = '{1'b1, 1'b0, 2'b00, 18'h00200, 16'h9999, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 16'hAB55, 16'h0000};
    tbl[4] = '{1'b0, 1'b0, 2'b01, 18'h00040, 16'h1234, 8'h1E, 8'h00, 8'h1C, 8'h00, 8'h1C, 8'h3E, 8'h3E, 8'h20, 16'hAB55, 16'h0034};
    tbl[5] = '{1'b1, 1'b1, 2'b11, 18'h00040, 16'h5678, 8'h1E, 8'h00, 8'h1C, 8'h1C, 8'h1C, 8'h3E, 8'h3E, 8'h20, 16'hAB55, 16'h5678};
    tbl[6] = '{1'b1, 1'b1, 2'b00, 18'h00040, 16'h0000, 8'h1E, 8'h1E, 8'h00, 8'h1E, 8'h1E, 8'h00, 8'h3E, 8'h20, 16'h5678, 16'h5678};
    tbl[7] = '{1'b0, 1'b0, 2'b11, 18'h3FFFF, 16'hBEEF, 8'h1E, 8'h00, 8'h1C, 8'h1C, 8'h1C, 8'h3E, 8'h3E, 8'h20, 16'h5678, 16'hBEEF};
    tbl[8] = '{1'b0, 1'b1, 2'b00, 18'h3FFFF, 16'h0000, 8'h1E, 8'h1E, 8'h00, 8'h1E, 8'h1E, 8'h00, 8'h3E, 8'h20, 16'hBEEF, 16'hBEEF};
    i0.req = 0; i0.addr = '0; i0.r = 0; i0.w = '0; i0.wdata = '0;
    i1.req = 0; i1.addr = '0; i1.r = 0; i1.w = '0; i1.wdata = '0;
    j0.req = 0; j0.addr = '0; j0.r = 0; j0.w = '0; j0.wdata = '0;
    j1.req = 0; j1.addr = '0; j1.r = 0; j1.w = '0; j1.wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);
    chk("reset dq_oe", dq_oe, 1'b0);
    chk("reset sram_addr", sram_addr, 18'h0);
    chk("reset dq_o", dq_o, 16'h0);
    chk("reset rdata", rdata, 16'h0);
    chk("reset acks", {i1.ack, i0.ack}, 2'b00);
    chk("reset busy", busy, 1'b0);
    chk("reset grant", grant, 1'b0);

    for (int i = 0; i < 9; i++) run_txn(i, tbl[i]);

    // both ports request continuously from reset: expect alternation 0,1,0,1 every 6 cycles
    @(posedge clk); #1;
    reset = 1'b1;
    i0.addr = 18'h00123; i0.r = 1'b1; i0.w = 2'b00; i0.req = 1'b1;
    i1.addr = 18'h00040; i1.r = 1'b1; i1.w = 2'b00; i1.req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 4; k++) begin ack_port[k] = -1; ack_cyc[k] = -1; ack_gnt[k] = -1; end
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if ((i0.ack || i1.ack) && n < 4) begin
        ack_port[n] = i1.ack ? 1 : 0;
        ack_cyc[n] = c;
        ack_gnt[n] = int'(grant);
        n++;
      end
    end
    i0.req = 1'b0; i1.req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr ack %0d port", k), ack_port[k], k % 2);
      chk($sformatf("rr ack %0d cycle", k), ack_cyc[k], 5 + 6 * k);
      chk($sformatf("rr ack %0d grant", k), ack_gnt[k], k % 2);
    end
    repeat (10) @(posedge clk);

    // reset pulsed in cycle 3 of a write; held request re-served from scratch
    #1;
    i1.addr = 18'h00050; i1.r = 1'b0; i1.w = 2'b11; i1.wdata = 16'hCAFE; i1.req = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid reset strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);
    chk("mid reset dq_oe", dq_oe, 1'b0);
    chk("mid reset ack", {i1.ack, i0.ack}, 2'b00);
    chk("mid reset busy", busy, 1'b0);
    ackc = -1;
    for (int c = 5; c < 16; c++) begin
      @(negedge clk);
      if (i1.ack && ackc < 0) begin
        ackc = c;
        i1.req = 1'b0;
      end
    end
    chk("re-served ack cycle", ackc, 9);
    chk("re-served sram word", mem[8'h50], 16'hCAFE);

    // WAIT=1 build: write acks in cycle 3 with a single we_n low cycle
    @(posedge clk); #1;
    j1.addr = 18'h00005; j1.r = 1'b0; j1.w = 2'b11; j1.wdata = 16'h1111; j1.req = 1'b1;
    ce = '0; we = '0; ak = '0; dqoe = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ce[c] = !w1_ce_n; we[c] = !w1_we_n; ak[c] = j1.ack; dqoe[c] = w1_dq_oe;
      if (j1.ack) j1.req = 1'b0;
    end
    chk("w1 ce_n low cycles", ce, 8'h06);
    chk("w1 we_n low cycles", we, 8'h04);
    chk("w1 ack cycles", ak, 8'h08);
    chk("w1 dq_oe cycles", dqoe, 8'h0E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
